// File: rtl/radix2_div_pipe_ctl_pkg.sv
// Shared definitions for the radix-2 divide unit:
// FSM encoding and result field layout.
package radix2_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int QUO_LSB = 0;

  // Remainder sits directly above the quotient.
  function automatic int rem_lsb(input int width);
    return width;
  endfunction

endpackage

// File: rtl/radix2_div_pipe_ctl_if.sv
// Request/response bundle of the divide unit.
// master = requester, slave = divider.
interface radix2_div_pipe_ctl_if #(
  parameter int WIDTH = 8
);

  logic               opn_valid;
  logic               opn_ready;
  logic               sign;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               res_valid;
  logic               res_ready;
  logic [2*WIDTH-1:0] result;
  logic               div_by_zero;

  modport master (
    output opn_valid,
    output sign,
    output dividend,
    output divisor,
    output res_ready,
    input  opn_ready,
    input  res_valid,
    input  result,
    input  div_by_zero
  );

  modport slave (
    input  opn_valid,
    input  sign,
    input  dividend,
    input  divisor,
    input  res_ready,
    output opn_ready,
    output res_valid,
    output result,
    output div_by_zero
  );

endinterface

// File: rtl/radix2_div_pipe_ctl_step.sv
// One restoring-division iteration: shift the
// {rem,quo} pair left, trial-subtract, restore on borrow.
module radix2_div_step
  import radix2_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nx,
  output logic [WIDTH-1:0] quo_nx
);

  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  assign sh     = {rem, quo[WIDTH-1]};
  assign diff   = {1'b0, sh} - {2'b00, divisor};
  assign borrow = diff[WIDTH+1];

  // rem < divisor on entry, so the kept value fits WIDTH bits.
  assign rem_nx = borrow ? sh[WIDTH-1:0]
                         : diff[WIDTH-1:0];
  assign quo_nx = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/radix2_div_pipe_ctl.sv
// Shared multi-cycle divider: one quotient bit per
// clock, signed or unsigned, result held until taken.
module radix2_div_pipe_ctl
  import radix2_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  radix2_div_pipe_ctl_if.slave bus
);

  localparam int CNT_W   = $clog2(WIDTH + 1);
  localparam int REM_LSB = rem_lsb(WIDTH);

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               neg_q;
  logic               neg_r;
  logic [CNT_W-1:0]   cnt;
  logic               res_valid;
  logic [2*WIDTH-1:0] res_q;
  logic               dz_q;

  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic             dvd_neg;
  logic             dvs_neg;
  logic             accept;
  logic             last;
  logic             hs;
  logic             dz_in;

  assign dvd_neg = bus.sign & bus.dividend[WIDTH-1];
  assign dvs_neg = bus.sign & bus.divisor[WIDTH-1];

  // -MIN wraps to MIN, which read unsigned is 2^(WIDTH-1).
  assign dvd_abs = dvd_neg ? -bus.dividend
                           : bus.dividend;
  assign dvs_abs = dvs_neg ? -bus.divisor
                           : bus.divisor;

  assign dz_in  = (bus.divisor == '0);
  assign accept = (state == IDLE) & bus.opn_valid;
  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign hs     = (state == DONE) & bus.res_ready;

  assign q_fix = neg_q ? -quo_nx : quo_nx;
  assign r_fix = neg_r ? -rem_nx : rem_nx;

  radix2_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem    (rem_q),
    .quo    (quo_q),
    .divisor(dvs_q),
    .rem_nx (rem_nx),
    .quo_nx (quo_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.opn_valid) begin
          state_nx = dz_in ? DONE : CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_q     <= '0;
      dz_q      <= 1'b0;
    end else begin
      if (accept) begin
        rem_q <= '0;
        quo_q <= dvd_abs;
        dvs_q <= dvs_abs;
        neg_q <= dvd_neg ^ dvs_neg;
        neg_r <= dvd_neg;
        cnt   <= '0;
        if (dz_in) begin
          res_q[REM_LSB +: WIDTH] <= bus.dividend;
          res_q[QUO_LSB +: WIDTH] <= '1;
          dz_q      <= 1'b1;
          res_valid <= 1'b1;
        end
      end else if (state == CALC) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt   <= cnt + CNT_W'(1);
        if (last) begin
          res_q[REM_LSB +: WIDTH] <= r_fix;
          res_q[QUO_LSB +: WIDTH] <= q_fix;
          dz_q      <= 1'b0;
          res_valid <= 1'b1;
        end
      end else if (hs) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign bus.opn_ready   = (state == IDLE);
  assign bus.res_valid   = res_valid;
  assign bus.result      = res_q;
  assign bus.div_by_zero = dz_q;

endmodule
